// File: rtl/ted_instruction_prefetch_if.sv
// Fetch-side bus bundle: Avalon read port to instruction memory plus the decoder valid/ready handshake.
interface ted_instruction_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    input  mem_readdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    output mem_readdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/ted_instruction_prefetch.sv
// Sequential instruction prefetcher: 1-cycle memory reads into a DEPTH-entry FIFO, redirect/flush, OOB halt.
// Optional TED_PREFETCH_STATS_EN adds saturating fetched/stall counters.
module ted_instruction_prefetch #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 45000,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  ted_instruction_prefetch_if.master bus,
  output logic                 pc_oob
`ifdef TED_PREFETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_stall
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_WORDS - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;
  logic              issue, push, pop, redirect_oob;

  // Space for the inflight word is reserved at issue, so a landing response always fits.
  assign issue = (state == ST_RUN) && fetch_en && !redirect_valid &&
                 ((count + (PTR_W+1)'(inflight)) < (PTR_W+1)'(DEPTH));
  assign push  = inflight && !redirect_valid;
  assign pop   = bus.instr_valid && bus.instr_ready && !redirect_valid;
  assign redirect_oob = 32'(redirect_pc) >= 32'(MEM_WORDS);

  assign bus.mem_address    = issue ? pc : '0;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;

  // Head outputs fall back to the last shown value so they hold while the FIFO is empty.
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = bus.instr_valid ? data_q[rd_ptr] : hold_data;
  assign bus.instr_pc    = bus.instr_valid ? pc_q[rd_ptr]   : hold_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      hold_data   <= '0;
      hold_pc     <= '0;
      pc_oob      <= 1'b0;
    end else begin
      inflight  <= issue;
      hold_data <= bus.instr_data;
      hold_pc   <= bus.instr_pc;
      if (issue) inflight_pc <= pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        pc     <= redirect_pc;
        state  <= redirect_oob ? ST_HALT : ST_RUN;
        pc_oob <= redirect_oob;
      end else begin
        if (issue)  pc     <= (pc == LAST_PC) ? '0 : pc + 1'b1;
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.mem_readdata;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef TED_PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && stat_fetched != 32'hFFFF_FFFF) stat_fetched <= stat_fetched + 1'b1;
      if (!bus.instr_valid && state == ST_RUN && fetch_en && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule
